// File: rtl/btn_conditioner_pkg.sv
// Shared constants for the button front end: button indices, default 50 MHz timing
// and the auto-repeat phase type used by each channel.
package btn_conditioner_pkg;

    localparam int unsigned NUM_BTN   = 6;
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_ENTER = 4;
    localparam int unsigned BTN_ESC   = 5;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;
    localparam int unsigned DEF_CNT_W           = 25;
    localparam logic [NUM_BTN-1:0] DEF_REPEAT_MASK = 6'b000011;

    typedef enum logic [1:0] {
        REP_IDLE,
        REP_DELAY,
        REP_PERIOD
    } rep_state_e;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between board pins and the watch: raw active-low inputs in,
// press pulses and debounced levels out.
interface btn_conditioner_if;
    import btn_conditioner_pkg::*;

    logic [NUM_BTN-1:0] btn_n_i;
    logic [NUM_BTN-1:0] pulse_o;
    logic [NUM_BTN-1:0] level_o;

    modport master (output btn_n_i, input  pulse_o, input  level_o);
    modport slave  (input  btn_n_i, output pulse_o, output level_o);

endinterface

// File: rtl/btn_conditioner_channel.sv
// One button: 2-flop synchronizer, debounce counter, registered press edge and
// optional auto-repeat timer.
module btn_channel
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic pulse_o,
    output logic level_o
);

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             level_q, pulse_q, pulse_d;
    rep_state_e       rstate_q, rstate_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             pressed, press, rep_fire;

    assign pressed = ~sync2_q;
    assign press   = deb_q & ~level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            deb_q    <= 1'b0;
            dcnt_q   <= '0;
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
            rstate_q <= REP_IDLE;
            rcnt_q   <= '0;
        end else begin
            sync1_q  <= btn_n_i;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            dcnt_q   <= dcnt_d;
            level_q  <= deb_q;
            pulse_q  <= pulse_d;
            rstate_q <= rstate_d;
            rcnt_q   <= rcnt_d;
        end
    end

    always_comb begin
        deb_d  = deb_q;
        dcnt_d = dcnt_q;
        if (pressed == deb_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DEB_LAST) begin
            deb_d  = ~deb_q;
            dcnt_d = '0;
        end else if (dcnt_q != '1) begin
            dcnt_d = dcnt_q + ONE;
        end
    end

    // Any synced release ends the repeat run at once, before the debounced level falls.
    always_comb begin
        rstate_d = rstate_q;
        rcnt_d   = rcnt_q;
        rep_fire = 1'b0;
        if (REPEAT_EN) begin
            if (press) begin
                rstate_d = REP_DELAY;
                rcnt_d   = '0;
            end else if (rstate_q != REP_IDLE) begin
                if (!pressed) begin
                    rstate_d = REP_IDLE;
                    rcnt_d   = '0;
                end else if (rcnt_q == ((rstate_q == REP_DELAY) ? DELAY_LAST : PER_LAST)) begin
                    rep_fire = 1'b1;
                    rstate_d = REP_PERIOD;
                    rcnt_d   = '0;
                end else if (rcnt_q != '1) begin
                    rcnt_d = rcnt_q + ONE;
                end
            end
        end
    end

    assign pulse_d = press | rep_fire;
    assign pulse_o = pulse_q;
    assign level_o = level_q;

endmodule

// File: rtl/btn_conditioner.sv
// Watch input front end: one independent conditioning channel per push-button.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned        DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned        REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned        REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = DEF_REPEAT_MASK,
    parameter int unsigned        CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    btn_conditioner_if.slave bus
);

    logic [NUM_BTN-1:0] pulse;
    logic [NUM_BTN-1:0] level;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .CNT_W           (CNT_W),
            .REPEAT_EN       (REPEAT_MASK[g])
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .btn_n_i (bus.btn_n_i[g]),
            .pulse_o (pulse[g]),
            .level_o (level[g])
        );
    end

    assign bus.pulse_o = pulse;
    assign bus.level_o = level;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed edge-exact scenarios plus randomized
// toggling checked against a history-window reference model.
module tb_btn_conditioner;
    import btn_conditioner_pkg::*;

    localparam int unsigned D    = 4;
    localparam int unsigned RD   = 10;
    localparam int unsigned RP   = 3;
    localparam logic [5:0]  MASK = 6'b000011;
    localparam int          HMAX = 32768;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btn_conditioner_if bif();

    btn_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (MASK),
        .CNT_W           (25)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: rh[n] = pressed value sampled at edge n. A level flips when
    // the D samples seen by the debouncer all disagree with it; repeats fall on
    // press+RD+k*RP while every sample since the press stayed pressed.
    logic [5:0] rh [0:HMAX-1];
    int         cyc = 0;
    int         rstlast = -10;
    int         tp [6];
    int         lastrel [6];
    logic [5:0] mL = '0;
    logic [5:0] mP = '0;

    always @(posedge clk) begin
        int  n;
        logic flip;
        n = cyc;
        if (rst) begin
            rh[n] = '0;
            if (n > 0) rh[n-1] = '0;
            mL = '0;
            mP = '0;
            rstlast = n;
            for (int i = 0; i < 6; i++) begin
                tp[i] = -1000;
                lastrel[i] = n;
            end
        end else begin
            rh[n] = ~bif.btn_n_i;
            if (n == rstlast + 1) begin
                mL = '0;
                mP = '0;
            end else begin
                for (int i = 0; i < 6; i++) begin
                    flip = 1'b1;
                    for (int j = 3; j <= int'(D) + 2; j++) begin
                        if (n - j < 0) flip = 1'b0;
                        else if (rh[n-j][i] == mL[i]) flip = 1'b0;
                    end
                    if (!rh[n-2][i] && (n - 2 > lastrel[i])) lastrel[i] = n - 2;
                    mP[i] = 1'b0;
                    if (flip) begin
                        mL[i] = ~mL[i];
                        if (mL[i]) begin
                            mP[i] = 1'b1;
                            tp[i] = n;
                        end
                    end else if (MASK[i] && mL[i] && (n - tp[i] >= int'(RD)) &&
                                 ((n - tp[i] - int'(RD)) % int'(RP) == 0) &&
                                 (lastrel[i] < tp[i] - 1)) begin
                        mP[i] = 1'b1;
                    end
                end
            end
        end
        cyc = cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bif.btn_n_i = '1;
        tick();
        tick();
        rst = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        bif.btn_n_i = '0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (bif.level_o !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_level got=%b exp=%b", bif.level_o, 6'b0);
        end
        n_cmp++;
        if (bif.pulse_o !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_pulse got=%b exp=%b", bif.pulse_o, 6'b0);
        end
        tick();
        rst = 1'b0;
        bif.btn_n_i = '1;
        repeat (8) tick();
        n_cmp++;
        if ({bif.level_o, bif.pulse_o} !== 12'b0) begin
            n_bad++;
            $display("FAIL reset_idle got=%b exp=%b", {bif.level_o, bif.pulse_o}, 12'b0);
        end
    endtask

    task automatic test_single_press();
        logic [5:0] el, ep;
        do_reset();
        bif.btn_n_i[4] = 1'b0;
        for (int e = 0; e <= 56; e++) begin
            tick();
            el = (e >= 6) ? 6'b010000 : 6'b0;
            ep = (e == 6) ? 6'b010000 : 6'b0;
            n_cmp++;
            if (bif.level_o !== el) begin
                n_bad++;
                $display("FAIL press_level e=%0d got=%b exp=%b", e, bif.level_o, el);
            end
            n_cmp++;
            if (bif.pulse_o !== ep) begin
                n_bad++;
                $display("FAIL press_pulse e=%0d got=%b exp=%b", e, bif.pulse_o, ep);
            end
        end
        bif.btn_n_i = '1;
    endtask

    task automatic test_bounce();
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                bif.btn_n_i[2] = (c == 3);
                tick();
                n_cmp++;
                if ({bif.level_o, bif.pulse_o} !== 12'b0) begin
                    n_bad++;
                    $display("FAIL bounce r=%0d c=%0d got=%b exp=%b", r, c,
                             {bif.level_o, bif.pulse_o}, 12'b0);
                end
            end
        end
        bif.btn_n_i[2] = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            n_cmp++;
            if ({bif.level_o, bif.pulse_o} !== 12'b0) begin
                n_bad++;
                $display("FAIL bounce_tail e=%0d got=%b exp=%b", e,
                         {bif.level_o, bif.pulse_o}, 12'b0);
            end
        end
    endtask

    task automatic test_repeat();
        logic [5:0] el, ep;
        do_reset();
        bif.btn_n_i[0] = 1'b0;
        for (int e = 0; e <= 40; e++) begin
            if (e == 23) bif.btn_n_i[0] = 1'b1;
            tick();
            el = (e >= 6 && e <= 28) ? 6'b000001 : 6'b0;
            ep = (e == 6 || e == 16 || e == 19 || e == 22) ? 6'b000001 : 6'b0;
            n_cmp++;
            if (bif.level_o !== el) begin
                n_bad++;
                $display("FAIL repeat_level e=%0d got=%b exp=%b", e, bif.level_o, el);
            end
            n_cmp++;
            if (bif.pulse_o !== ep) begin
                n_bad++;
                $display("FAIL repeat_pulse e=%0d got=%b exp=%b", e, bif.pulse_o, ep);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [5:0] el, ep;
        do_reset();
        bif.btn_n_i[0] = 1'b0;
        bif.btn_n_i[5] = 1'b0;
        for (int e = 0; e <= 12; e++) begin
            tick();
            el = (e >= 6) ? 6'b100001 : 6'b0;
            ep = (e == 6) ? 6'b100001 : 6'b0;
            n_cmp++;
            if (bif.level_o !== el) begin
                n_bad++;
                $display("FAIL simul_level e=%0d got=%b exp=%b", e, bif.level_o, el);
            end
            n_cmp++;
            if (bif.pulse_o !== ep) begin
                n_bad++;
                $display("FAIL simul_pulse e=%0d got=%b exp=%b", e, bif.pulse_o, ep);
            end
        end
        bif.btn_n_i = '1;
    endtask

    task automatic test_reset_held();
        logic [5:0] el, ep;
        do_reset();
        bif.btn_n_i[1] = 1'b0;
        for (int e = 0; e <= 25; e++) begin
            rst = (e == 10 || e == 11);
            tick();
            if (e != 10) begin
                el = ((e >= 6 && e <= 9) || e >= 18) ? 6'b000010 : 6'b0;
                ep = (e == 6 || e == 18) ? 6'b000010 : 6'b0;
                n_cmp++;
                if (bif.level_o !== el) begin
                    n_bad++;
                    $display("FAIL rsthold_level e=%0d got=%b exp=%b", e, bif.level_o, el);
                end
                n_cmp++;
                if (bif.pulse_o !== ep) begin
                    n_bad++;
                    $display("FAIL rsthold_pulse e=%0d got=%b exp=%b", e, bif.pulse_o, ep);
                end
            end
        end
        rst = 1'b0;
        bif.btn_n_i = '1;
    endtask

    task automatic test_random();
        int         hold [6];
        logic [5:0] prevp;
        do_reset();
        prevp = '0;
        for (int i = 0; i < 6; i++) hold[i] = $urandom_range(1, 24);
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 6; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    bif.btn_n_i[i] = ~bif.btn_n_i[i];
                    hold[i] = $urandom_range(1, 24);
                end
            end
            tick();
            n_cmp++;
            if (bif.level_o !== mL) begin
                n_bad++;
                $display("FAIL rand_level c=%0d got=%b exp=%b", c, bif.level_o, mL);
            end
            n_cmp++;
            if (bif.pulse_o !== mP) begin
                n_bad++;
                $display("FAIL rand_pulse c=%0d got=%b exp=%b", c, bif.pulse_o, mP);
            end
            n_cmp++;
            if ((bif.pulse_o & prevp & ~MASK) !== 6'b0) begin
                n_bad++;
                $display("FAIL rand_double_pulse c=%0d got=%b exp=%b", c,
                         bif.pulse_o & prevp & ~MASK, 6'b0);
            end
            prevp = bif.pulse_o;
        end
        bif.btn_n_i = '1;
    endtask

    initial begin
        rst = 1'b1;
        bif.btn_n_i = '1;
        do_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_repeat();
        test_simultaneous();
        test_reset_held();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
